xocc_dsa_acc_engine: RTL and testbench



---
 rtl/xocc_dsa_pkg.sv | 39 +++
 rtl/xocc_dsa_acc_engine.sv | 152 +++++++++++++++
 tb/tb_xocc_dsa_acc_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xocc_dsa_pkg.sv
// ---------------------------------------------------------------------------
// xocc_dsa_pkg
// Shared definitions for the XOCC DSA accumulate engine:
//   - command word field positions (op / tag / imm)
//   - opcode encodings and the error-response prefix
//   - FSM state encoding
//   - sign extension of the 24-bit immediate
// ---------------------------------------------------------------------------
package xocc_dsa_pkg;

   // Command word field positions
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 28;
   localparam int TAG_MSB = 27;
   localparam int TAG_LSB = 24;
   localparam int IMM_MSB = 23;
   localparam int IMM_LSB = 0;

   // Opcodes
   localparam logic [3:0] OP_CLR   = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_SUM_N = 4'h3;
   localparam logic [3:0] OP_READ  = 4'h4;

   // Top nibble of the response produced for an illegal opcode
   localparam logic [3:0] ERR_PREFIX = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ADD immediates are two's complement; widen to the 32-bit accumulator.
   function automatic logic signed [31:0] sext_imm(input logic signed [IMM_MSB:IMM_LSB] imm);
      return 32'(imm);
   endfunction

endpackage

// File: rtl/xocc_dsa_acc_engine.sv
// ---------------------------------------------------------------------------
// xocc_dsa_acc_engine
// Accumulator engine sitting behind one XOCC channel. Pops 32-bit commands
// from a first-word-fall-through command FIFO, executes CLR / ADD / SUM_N /
// READ and pushes 32-bit results into the response FIFO.
//
// Ports
//   xocc_clk         in   DSA clock
//   xocc_rst         in   synchronous active-high reset
//   xocc_cmd_buffer  in   head word of the command FIFO (valid when !empty)
//   xocc_cmd_empty   in   command FIFO empty
//   xocc_cmd_rd_en   out  pop the head command word this cycle
//   xocc_rsp_buffer  out  registered response word
//   xocc_rsp_full    in   response FIFO full
//   xocc_rsp_wr_en   out  push xocc_rsp_buffer this cycle
//   busy             out  engine is not idle
//   err_cnt          out  illegal-opcode count, saturating at 255
// ---------------------------------------------------------------------------
module xocc_dsa_acc_engine
   import xocc_dsa_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              xocc_clk,
   input  logic              xocc_rst,
   input  logic [DATA_W-1:0] xocc_cmd_buffer,
   input  logic              xocc_cmd_empty,
   output logic              xocc_cmd_rd_en,
   output logic [DATA_W-1:0] xocc_rsp_buffer,
   input  logic              xocc_rsp_full,
   output logic              xocc_rsp_wr_en,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   state_t              state;
   state_t              state_d;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   sum;
   logic [DATA_W-1:0]   sum_nxt;
   logic [DATA_W-1:0]   rsp;
   logic [LEN_W-1:0]    remaining;
   logic [7:0]          errs;
   logic                pop;
   logic                push;

   logic [3:0]          op;
   logic [3:0]          tag;
   logic signed [23:0]  imm;
   logic [LEN_W-1:0]    len;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign op      = xocc_cmd_buffer[OP_MSB:OP_LSB];
   assign tag     = xocc_cmd_buffer[TAG_MSB:TAG_LSB];
   assign imm     = xocc_cmd_buffer[IMM_MSB:IMM_LSB];
   assign len     = xocc_cmd_buffer[LEN_W-1:0];
   assign sum_nxt = sum + xocc_cmd_buffer;

   // Next state and handshakes. Reset forces both handshakes low so the
   // FIFOs see no traffic during any reset cycle. wr_en depends only on
   // state and full, never on the command word.
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      push    = 1'b0;
      if (!xocc_rst) begin
         case (state)
            ST_IDLE: begin
               pop = ~xocc_cmd_empty;
               if (pop) begin
                  case (op)
                     OP_CLR, OP_ADD: state_d = ST_IDLE;
                     OP_SUM_N:       state_d = (len != '0) ? ST_DATA : ST_RESP;
                     default:        state_d = ST_RESP;
                  endcase
               end
            end
            ST_DATA: begin
               pop = ~xocc_cmd_empty;
               if (pop && remaining == LEN_W'(1)) begin
                  state_d = ST_RESP;
               end
            end
            ST_RESP: begin
               push = ~xocc_rsp_full;
               if (push) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Registered state, accumulator, running sum and response word
   always_ff @(posedge xocc_clk) begin
      if (xocc_rst) begin
         state     <= ST_IDLE;
         acc       <= '0;
         sum       <= '0;
         remaining <= '0;
         rsp       <= '0;
         errs      <= '0;
      end else begin
         state <= state_d;
         if (pop) begin
            case (state)
               ST_IDLE: begin
                  case (op)
                     OP_CLR: acc <= '0;
                     OP_ADD: acc <= acc + DATA_W'(sext_imm(imm));
                     OP_SUM_N: begin
                        if (len != '0) begin
                           sum       <= '0;
                           remaining <= len;
                        end else begin
                           rsp <= '0;
                        end
                     end
                     OP_READ: rsp <= acc;
                     default: begin
                        rsp  <= DATA_W'({ERR_PREFIX, 20'h0, op, tag});
                        errs <= sat_inc8(errs);
                     end
                  endcase
               end
               ST_DATA: begin
                  // Data words are raw operands, never decoded as opcodes.
                  sum       <= sum_nxt;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     acc <= acc + sum_nxt;
                     rsp <= sum_nxt;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign xocc_cmd_rd_en  = pop;
   assign xocc_rsp_wr_en  = push;
   assign xocc_rsp_buffer = rsp;
   assign busy            = (state != ST_IDLE) && !xocc_rst;
   assign err_cnt         = errs;

endmodule

// File: tb/tb_xocc_dsa_acc_engine.sv
// ---------------------------------------------------------------------------
// tb_xocc_dsa_acc_engine
// Self-checking bench for xocc_dsa_acc_engine. A software FIFO feeds the
// command port; a transaction-level model predicts every response and
// pushes it into a scoreboard queue that a separate monitor drains.
// ---------------------------------------------------------------------------
module tb_xocc_dsa_acc_engine;

   logic        clk;
   logic        rst;
   logic [31:0] cmd_buffer;
   logic        cmd_empty;
   logic        cmd_rd_en;
   logic [31:0] rsp_buffer;
   logic        rsp_full;
   logic        rsp_wr_en;
   logic        busy;
   logic [7:0]  err_cnt;

   xocc_dsa_acc_engine #(.DATA_W(32), .LEN_W(16)) dut (
      .xocc_clk        (clk),
      .xocc_rst        (rst),
      .xocc_cmd_buffer (cmd_buffer),
      .xocc_cmd_empty  (cmd_empty),
      .xocc_cmd_rd_en  (cmd_rd_en),
      .xocc_rsp_buffer (rsp_buffer),
      .xocc_rsp_full   (rsp_full),
      .xocc_rsp_wr_en  (rsp_wr_en),
      .busy            (busy),
      .err_cnt         (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- command FIFO model --------------------------------------------
   logic [31:0] fifo_mem [4096];
   int          wp;
   int          rp;
   logic        hold_empty;
   logic        full_req;
   logic        rand_full;
   logic        rand_gap;
   logic        full_bit;
   logic        gap_bit;

   assign cmd_buffer = fifo_mem[rp % 4096];
   assign cmd_empty  = (wp == rp) || hold_empty || (rand_gap && gap_bit);
   assign rsp_full   = full_req || (rand_full && full_bit);

   // ---- scoreboard and reference model state ---------------------------
   logic [31:0] expq[$];
   logic [31:0] macc;
   int          merr;
   int          n_cmp;
   int          n_bad;
   logic [31:0] words[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h required %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [31:0] w);
      fifo_mem[wp % 4096] = w;
      wp++;
   endtask

   task automatic send_clr();
      push_word({4'h1, 28'($urandom)});
      macc = 32'h0;
   endtask

   task automatic send_add(input logic [23:0] imm);
      logic signed [23:0] simm;
      simm = imm;
      push_word({4'h2, 4'($urandom), imm});
      macc = macc + 32'(simm);
   endtask

   // SUM_N over the words currently held in 'words'
   task automatic send_sum(input logic [3:0] tag);
      logic [31:0] s;
      s = 32'h0;
      push_word({4'h3, tag, 8'($urandom), 16'(words.size())});
      foreach (words[i]) begin
         push_word(words[i]);
         s = s + words[i];
      end
      macc = macc + s;
      expq.push_back(s);
   endtask

   task automatic send_read();
      push_word({4'h4, 28'($urandom)});
      expq.push_back(macc);
   endtask

   task automatic send_illegal(input logic [31:0] w);
      push_word(w);
      expq.push_back({4'hE, 20'h0, w[31:28], w[27:24]});
      if (merr < 255) merr++;
   endtask

   task automatic wait_drain(input string name);
      int i;
      i = 0;
      while (wp != rp && i < 500) begin
         tick();
         i++;
      end
      if (wp != rp) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: drain timeout, fifo holds %0d words, required 0", name, wp - rp);
      end
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      while (!(wp == rp && !busy && expq.size() == 0) && i < 3000) begin
         tick();
         i++;
      end
      if (i >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: idle timeout, pending rsp %0d busy %0b, required 0/0", name, expq.size(), busy);
      end
   endtask

   // ---- FIFO pop side: a pop granted before the edge retires the head ----
   initial begin
      logic pop_now;
      forever begin
         @(negedge clk);
         pop_now = cmd_rd_en;
         if (pop_now && wp == rp) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_empty: rd_en=1 required 0 with fifo empty");
         end
         @(posedge clk);
         #1;
         if (pop_now) rp++;
      end
   end

   // ---- random backpressure / gaps ---------------------------------------
   initial begin
      full_bit = 1'b0;
      gap_bit  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         full_bit = ($urandom_range(0, 2) == 0);
         gap_bit  = ($urandom_range(0, 3) == 0);
      end
   end

   // ---- response monitor -------------------------------------------------
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rsp_wr_en === 1'b1) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: got %08h required no response", rsp_buffer);
            end else begin
               e = expq.pop_front();
               check("rsp", rsp_buffer, e);
            end
         end
      end
   end

   // ---- watchdog ---------------------------------------------------------
   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---- stimulus ---------------------------------------------------------
   initial begin
      logic [31:0] r_exp;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [3:0]  iop;
      n_cmp      = 0;
      n_bad      = 0;
      wp         = 0;
      rp         = 0;
      macc       = 32'h0;
      merr       = 0;
      rst        = 1'b1;
      hold_empty = 1'b0;
      full_req   = 1'b0;
      rand_full  = 1'b0;
      rand_gap   = 1'b0;
      for (int i = 0; i < 4096; i++) fifo_mem[i] = 32'h0;

      // Reset: commands waiting in the FIFO must not be popped
      tick();
      tick();
      send_add(24'h000005);
      send_add(24'hFFFFFE);
      @(negedge clk);
      check("rst_rd_en", 32'(cmd_rd_en), 32'h0);
      check("rst_wr_en", 32'(rsp_wr_en), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rsp", rsp_buffer, 32'h0);
      check("rst_err", 32'(err_cnt), 32'h0);
      tick();
      rst = 1'b0;

      // ADD 5, ADD -2, READ -> 3; READ result one cycle after its pop
      send_read();
      wait_drain("t1_drain");
      @(negedge clk);
      check("read_latency_wr_en", 32'(rsp_wr_en), 32'h1);
      check("t1_rsp_value", rsp_buffer, 32'h00000003);
      wait_idle("t1");
      check("t1_err", 32'(err_cnt), 32'h0);

      // CLR, SUM_N len=3 (tag 2), READ -> 0x11, 0x11
      send_clr();
      words = '{32'hFFFFFFFF, 32'h00000002, 32'h00000010};
      send_sum(4'h2);
      send_read();
      wait_idle("t2");

      // SUM_N len=2 with a 5-cycle empty gap between the data words
      w0 = $urandom;
      w1 = $urandom;
      push_word({4'h3, 4'h5, 8'h00, 16'd2});
      push_word(w0);
      macc = macc + w0 + w1;
      expq.push_back(w0 + w1);
      wait_drain("t3_drain");
      hold_empty = 1'b1;
      push_word(w1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("gap_busy", 32'(busy), 32'h1);
         check("gap_rd_en", 32'(cmd_rd_en), 32'h0);
         tick();
      end
      hold_empty = 1'b0;
      wait_idle("t3");

      // READ under 4 cycles of response backpressure, another command queued
      full_req = 1'b1;
      r_exp = macc;
      send_read();
      wait_drain("t4_drain");
      send_add(24'h000001);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_wr_en", 32'(rsp_wr_en), 32'h0);
         check("full_rd_en", 32'(cmd_rd_en), 32'h0);
         check("full_rsp_stable", rsp_buffer, r_exp);
         tick();
      end
      full_req = 1'b0;
      wait_idle("t4");

      // Illegal opcode
      send_illegal(32'h9A000000);
      wait_idle("t5a");
      check("illegal_err1", 32'(err_cnt), 32'h1);
      for (int i = 0; i < 300; i++) begin
         iop = 4'($urandom_range(5, 16));
         send_illegal({iop, 28'($urandom)});
      end
      wait_idle("t5b");
      check("illegal_err_sat", 32'(err_cnt), 32'd255);

      // Reset in the middle of SUM_N len=4, READ afterwards sees acc=0
      send_add(24'h000123);
      push_word({4'h3, 4'h7, 8'h00, 16'd4});
      push_word($urandom);
      push_word($urandom);
      wait_drain("t6_drain");
      @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'h1);
      tick();
      rst  = 1'b1;
      macc = 32'h0;
      merr = 0;
      send_read();
      @(negedge clk);
      check("abort_rst_rd_en", 32'(cmd_rd_en), 32'h0);
      check("abort_rst_busy", 32'(busy), 32'h0);
      check("abort_rst_wr_en", 32'(rsp_wr_en), 32'h0);
      tick();
      rst = 1'b0;
      wait_idle("t6");
      check("abort_err", 32'(err_cnt), 32'h0);

      // Randomized mix with random backpressure and FIFO gaps
      rand_full = 1'b1;
      rand_gap  = 1'b1;
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 9))
            0:       send_clr();
            1, 2, 3: send_add(24'($urandom));
            4, 5, 6: begin
               words.delete();
               for (int k = 0; k < int'($urandom_range(0, 6)); k++) words.push_back($urandom);
               send_sum(4'($urandom));
            end
            7, 8:    send_read();
            default: begin
               iop = 4'($urandom_range(5, 16));
               send_illegal({iop, 28'($urandom)});
            end
         endcase
         if ($urandom_range(0, 3) == 0) tick();
      end
      send_read();
      tick();
      rand_full = 1'b0;
      rand_gap  = 1'b0;
      wait_idle("t7");
      check("rand_err", 32'(err_cnt), 32'(merr));
      check("final_pending", 32'(expq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
